// File: rtl/comm_pkg.sv
// ============================================================================
// Module      : comm_pkg
// Description : Shared constants, header field positions and receive FSM
//               state encoding for the link receive path.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package comm_pkg;

    localparam logic [15:0] BROADCAST_ID       = 16'hFFFF;
    localparam int          DEFAULT_FIFO_DEPTH = 32;

    localparam int HDR_DEST_MSB = 31;
    localparam int HDR_DEST_LSB = 16;
    localparam int HDR_LEN_MSB  = 15;
    localparam int HDR_LEN_LSB  = 8;

    localparam int PLD_W0_MSB = 31;
    localparam int PLD_W0_LSB = 16;
    localparam int PLD_W1_MSB = 15;
    localparam int PLD_W1_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_t;

endpackage : comm_pkg

`default_nettype wire

// File: rtl/rx_word_fifo.sv
// ============================================================================
// Module      : rx_word_fifo
// Description : Two-write, one-read show-ahead 16-bit word buffer with
//               occupancy output. DEPTH must be a power of two (>= 4).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_word_fifo #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    i_wr_cnt,
    input  logic [15:0]   i_wr_data0,
    input  logic [15:0]   i_wr_data1,
    input  logic          i_rd_req,
    output logic [15:0]   o_rd_data,
    output logic          o_rd_valid,
    output logic [AW:0]   o_count
);

    localparam int CW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic [AW-1:0] w_wr_ptr_p1;

    assign w_pop       = i_rd_req && (r_count != '0);
    assign w_wr_ptr_p1 = r_wr_ptr + AW'(1);

    // Storage carries no reset; an empty buffer is defined by the pointers.
    always_ff @(posedge clk) begin
        if (i_wr_cnt != 2'd0) begin
            r_mem[r_wr_ptr] <= i_wr_data0;
        end
        if (i_wr_cnt == 2'd2) begin
            r_mem[w_wr_ptr_p1] <= i_wr_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_wr_cnt);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(i_wr_cnt) - CW'(w_pop);
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_rd_valid = (r_count != '0);
    assign o_count    = r_count;

endmodule : rx_word_fifo

`default_nettype wire

// File: rtl/link_rx_deframer.sv
// ============================================================================
// Module      : link_rx_deframer
// Description : Parses 32-bit link packets into frames, buffers accepted
//               payload words for the GPP. Optional RX_DROP_COUNT_EN builds a
//               saturating rejected-frame counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module link_rx_deframer
    import comm_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_valid,
    input  logic [31:0] link_packet,
    input  logic [15:0] node_id,
    input  logic        gpp_rtr_signal,
    output logic [15:0] rx_data_out,
    output logic        rx_data_valid,
    output logic        rx_complete_flag,
    output logic        rx_drop_flag,
    output logic        rx_busy,
    output logic [7:0]  drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [7:0]    r_rem;
    logic [7:0]    w_rem_nxt;
    logic          r_complete;
    logic          r_drop;
    logic          w_complete_nxt;
    logic          w_drop_nxt;
    logic [1:0]    w_wr_cnt;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;
    logic [15:0]   w_dest;
    logic [7:0]    w_len;
    logic          w_addr_hit;
    logic          w_fits;
    logic [7:0]    w_step;
    logic [7:0]    w_rem_after;

    assign w_dest      = link_packet[HDR_DEST_MSB:HDR_DEST_LSB];
    assign w_len       = link_packet[HDR_LEN_MSB:HDR_LEN_LSB];
    assign w_addr_hit  = (w_dest == node_id) || (w_dest == BROADCAST_ID);
    assign w_free      = CW'(FIFO_DEPTH) - w_count;
    // Space is reserved here, so the payload phase can never overflow.
    assign w_fits      = ({24'd0, w_len} <= 32'(w_free));
    assign w_step      = (r_rem >= 8'd2) ? 8'd2 : r_rem;
    assign w_rem_after = r_rem - w_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rem      <= 8'd0;
            r_complete <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_complete <= w_complete_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_complete_nxt = 1'b0;
        w_drop_nxt     = 1'b0;
        w_wr_cnt       = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (link_valid && (w_len != 8'd0)) begin
                    w_rem_nxt = w_len;
                    if (w_addr_hit && w_fits) begin
                        w_state_nxt = ST_PAYLOAD;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                        w_drop_nxt  = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (link_valid) begin
                    w_wr_cnt  = w_step[1:0];
                    w_rem_nxt = w_rem_after;
                    if (w_rem_after == 8'd0) begin
                        w_state_nxt    = ST_IDLE;
                        w_complete_nxt = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (link_valid) begin
                    w_rem_nxt = w_rem_after;
                    if (w_rem_after == 8'd0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = 8'd0;
            end
        endcase
    end

    rx_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_cnt   (w_wr_cnt),
        .i_wr_data0 (link_packet[PLD_W0_MSB:PLD_W0_LSB]),
        .i_wr_data1 (link_packet[PLD_W1_MSB:PLD_W1_LSB]),
        .i_rd_req   (gpp_rtr_signal),
        .o_rd_data  (rx_data_out),
        .o_rd_valid (rx_data_valid),
        .o_count    (w_count)
    );

    assign rx_complete_flag = r_complete;
    assign rx_drop_flag     = r_drop;
    assign rx_busy          = (r_state == ST_PAYLOAD) || (r_state == ST_DISCARD);

`ifdef RX_DROP_COUNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= 8'd0;
        end else if (r_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 8'd0;
`endif

endmodule : link_rx_deframer

`default_nettype wire

// File: tb/tb_link_rx_deframer.sv
// ============================================================================
// Module      : tb_link_rx_deframer
// Description : Self-checking bench for link_rx_deframer (node_id 16'h0005,
//               FIFO_DEPTH 32): vector table plus multi-cycle sequences.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_link_rx_deframer;

`ifdef RX_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        link_valid;
    logic [31:0] link_packet;
    logic [15:0] node_id;
    logic        gpp_rtr_signal;
    logic [15:0] rx_data_out;
    logic        rx_data_valid;
    logic        rx_complete_flag;
    logic        rx_drop_flag;
    logic        rx_busy;
    logic [7:0]  drop_count;

    int n_checks;
    int n_errors;
    logic [15:0] q[$];

    link_rx_deframer #(.FIFO_DEPTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .link_valid       (link_valid),
        .link_packet      (link_packet),
        .node_id          (node_id),
        .gpp_rtr_signal   (gpp_rtr_signal),
        .rx_data_out      (rx_data_out),
        .rx_data_valid    (rx_data_valid),
        .rx_complete_flag (rx_complete_flag),
        .rx_drop_flag     (rx_drop_flag),
        .rx_busy          (rx_busy),
        .drop_count       (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [31:0] pkt;
        logic        rtr;
        logic        ev;
        logic [15:0] ed;
        logic        ec;
        logic        edr;
        logic        eb;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle against the reference queue: pop if requested and non-empty,
    // then append the nw words carried by pkt.
    task automatic hcycle(input string tag, input logic lv, input logic [31:0] pkt,
                          input logic rtr, input int nw);
        link_valid     = lv;
        link_packet    = pkt;
        gpp_rtr_signal = rtr;
        @(posedge clk);
        if (rtr && q.size() > 0) void'(q.pop_front());
        if (nw >= 1) q.push_back(pkt[31:16]);
        if (nw == 2) q.push_back(pkt[15:0]);
        #1;
        chk({tag, " valid"}, 32'(rx_data_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, " data"}, 32'(rx_data_out), 32'(q[0]));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        tbl[0]  = '{1'b1, 32'h0005_0300, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 32'hAAAA_BBBB, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 32'hCCCC_1111, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0009_0400, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 32'h1111_2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'h3333_4444, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'hFFFF_0200, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 32'h1234_5678, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 32'h0005_0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 32'h0005_0100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 32'h9999_0000, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

        rst            = 1'b1;
        link_valid     = 1'b0;
        link_packet    = 32'd0;
        node_id        = 16'h0005;
        gpp_rtr_signal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid",    32'(rx_data_valid),    32'd0);
        chk("reset complete", 32'(rx_complete_flag), 32'd0);
        chk("reset drop",     32'(rx_drop_flag),     32'd0);
        chk("reset busy",     32'(rx_busy),          32'd0);
        chk("reset dropcnt",  32'(drop_count),       32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            link_valid     = tbl[i].lv;
            link_packet    = tbl[i].pkt;
            gpp_rtr_signal = tbl[i].rtr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), 32'(rx_data_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("v%0d data", i), 32'(rx_data_out), 32'(tbl[i].ed));
            chk($sformatf("v%0d complete", i), 32'(rx_complete_flag), 32'(tbl[i].ec));
            chk($sformatf("v%0d drop", i),     32'(rx_drop_flag),     32'(tbl[i].edr));
            chk($sformatf("v%0d busy", i),     32'(rx_busy),          32'(tbl[i].eb));
        end
        chk("dropcnt after table", 32'(drop_count), DC_EN ? 32'd1 : 32'd0);

        // Fill to 30 words; LEN 4 does not fit, fits after two pops.
        q.delete();
        hcycle("fill hdr", 1'b1, 32'h0005_1E00, 1'b0, 0);
        chk("fill busy", 32'(rx_busy), 32'd1);
        for (int k = 0; k < 15; k++) begin
            hcycle($sformatf("fill p%0d", k), 1'b1,
                   {16'h0100 + 16'(2 * k), 16'h0101 + 16'(2 * k)}, 1'b0, 2);
        end
        chk("fill complete", 32'(rx_complete_flag), 32'd1);
        hcycle("nofit hdr", 1'b1, 32'h0005_0400, 1'b0, 0);
        chk("nofit drop", 32'(rx_drop_flag), 32'd1);
        chk("nofit busy", 32'(rx_busy),      32'd1);
        hcycle("nofit d0", 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
        hcycle("nofit d1", 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
        chk("nofit idle", 32'(rx_busy), 32'd0);
        hcycle("pop0", 1'b0, 32'd0, 1'b1, 0);
        hcycle("pop1", 1'b0, 32'd0, 1'b1, 0);
        hcycle("fit hdr", 1'b1, 32'h0005_0400, 1'b0, 0);
        chk("fit drop", 32'(rx_drop_flag), 32'd0);
        chk("fit busy", 32'(rx_busy),      32'd1);
        hcycle("fit p0", 1'b1, 32'h5555_6666, 1'b0, 2);
        hcycle("fit p1", 1'b1, 32'h7777_8888, 1'b0, 2);
        chk("fit complete", 32'(rx_complete_flag), 32'd1);
        chk("dropcnt after nofit", 32'(drop_count), DC_EN ? 32'd2 : 32'd0);
        for (int k = 0; k < 32; k++) hcycle($sformatf("drain%0d", k), 1'b0, 32'd0, 1'b1, 0);

        // Full-depth frame with the GPP popping every cycle, across wrap.
        hcycle("wrap hdr", 1'b1, 32'h0005_2000, 1'b1, 0);
        chk("wrap busy", 32'(rx_busy), 32'd1);
        for (int k = 0; k < 16; k++) begin
            hcycle($sformatf("wrap p%0d", k), 1'b1,
                   {16'h2000 + 16'(2 * k), 16'h2001 + 16'(2 * k)}, 1'b1, 2);
        end
        chk("wrap complete", 32'(rx_complete_flag), 32'd1);
        for (int k = 0; k < 20; k++) hcycle($sformatf("wdrain%0d", k), 1'b0, 32'd0, 1'b1, 0);

        // Reset in the middle of a frame.
        hcycle("mid hdr", 1'b1, 32'h0005_0600, 1'b0, 0);
        hcycle("mid p0",  1'b1, 32'h1111_2222, 1'b0, 2);
        link_valid = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("mid rst valid",    32'(rx_data_valid),    32'd0);
        chk("mid rst busy",     32'(rx_busy),          32'd0);
        chk("mid rst complete", 32'(rx_complete_flag), 32'd0);
        chk("mid rst drop",     32'(rx_drop_flag),     32'd0);
        chk("mid rst dropcnt",  32'(drop_count),       32'd0);
        hcycle("new hdr", 1'b1, 32'h0005_0200, 1'b0, 0);
        chk("new busy", 32'(rx_busy), 32'd1);
        hcycle("new p0", 1'b1, 32'h3333_4444, 1'b0, 2);
        chk("new complete", 32'(rx_complete_flag), 32'd1);
        hcycle("new pop0", 1'b0, 32'd0, 1'b1, 0);
        hcycle("new pop1", 1'b0, 32'd0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_link_rx_deframer

`default_nettype wire
